// File: rtl/mmd_pkg.sv
// Shared types and default constants for the MMD divide controller and its
// HK-MASH modulator interface.
package mmd_pkg;

  localparam int MMD_Y_WIDTH = 4;
  localparam int MMD_N_WIDTH = 8;
  localparam int MMD_MIN_DIV = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mmd_state_e;

endpackage

// File: rtl/mmd_div_sat.sv
// Adds the sign-extended modulator sample to the integer divide value and
// clamps the result to [MIN_DIV, 2^N_WIDTH-1], flagging any clamp.
module mmd_div_sat
  import mmd_pkg::*;
#(
  parameter int N_WIDTH = MMD_N_WIDTH,
  parameter int MIN_DIV = MMD_MIN_DIV
) (
  input  logic [N_WIDTH-1:0]     n_int_i,
  input  logic [MMD_Y_WIDTH-1:0] y_i,
  output logic [N_WIDTH-1:0]     n_o,
  output logic                   sat_o
);

  localparam int SW = N_WIDTH + 2;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_DIV);
  localparam logic signed [SW-1:0] MAX_S = $signed({2'b00, {N_WIDTH{1'b1}}});

  logic signed [SW-1:0] sum_s;

  // Two guard bits keep both the negative and the overflow cases representable
  assign sum_s = $signed({2'b00, n_int_i})
               + $signed({{(SW-MMD_Y_WIDTH){y_i[MMD_Y_WIDTH-1]}}, y_i});

  always_comb begin
    n_o   = N_WIDTH'(MIN_DIV);
    sat_o = 1'b0;
    if (sum_s < MIN_S) begin
      n_o   = N_WIDTH'(MIN_DIV);
      sat_o = 1'b1;
    end else if (sum_s > MAX_S) begin
      n_o   = {N_WIDTH{1'b1}};
      sat_o = 1'b1;
    end else begin
      n_o   = sum_s[N_WIDTH-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/mmd_div_ctrl.sv
// Fractional-N divide controller fed by the HK-MASH modulator.
// Define MMD_DIV_CTRL_DUTY_EN to build the near-50% duty divided clock.
module mmd_div_ctrl
  import mmd_pkg::*;
#(
  parameter int N_WIDTH = MMD_N_WIDTH,
  parameter int MIN_DIV = MMD_MIN_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [N_WIDTH-1:0]     n_int_i,
  input  logic [MMD_Y_WIDTH-1:0] y_i,
  output logic                   y_req_o,
  output logic                   div_o,
  output logic                   div_clk_o,
  output logic                   sat_o
);

  localparam logic [N_WIDTH-1:0] CNT_ONE = N_WIDTH'(1);

  mmd_state_e         state_q;
  logic [N_WIDTH-1:0] cnt_q;
  logic               div_q;
  logic               y_req_q;
  logic               sat_q;
  logic [N_WIDTH-1:0] n_s;
  logic               sat_s;
  logic               load_s;

  mmd_div_sat #(
    .N_WIDTH (N_WIDTH),
    .MIN_DIV (MIN_DIV)
  ) u_sat (
    .n_int_i (n_int_i),
    .y_i     (y_i),
    .n_o     (n_s),
    .sat_o   (sat_s)
  );

  assign load_s = (state_q == ST_RUN) && (cnt_q == '0) && en_i;

  // Period FSM: count down, reload with the clamped divide value at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      y_req_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      div_q   <= 1'b0;
      y_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (en_i) begin
            cnt_q   <= n_s - CNT_ONE;
            div_q   <= 1'b1;
            y_req_q <= 1'b1;
            sat_q   <= sat_q | sat_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign div_o   = div_q;
  assign y_req_o = y_req_q;
  assign sat_o   = sat_q;

`ifdef MMD_DIV_CTRL_DUTY_EN
  logic [N_WIDTH-1:0] n_cur_q;
  logic [N_WIDTH-1:0] n_half_s;
  logic               div_clk_q;

  assign n_half_s = n_cur_q >> 1;

  // High while the remaining count is at least floor(N/2): ceil(N/2) cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cur_q   <= '0;
      div_clk_q <= 1'b0;
    end else if (load_s) begin
      n_cur_q   <= n_s;
      div_clk_q <= 1'b1;
    end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
      div_clk_q <= (cnt_q > n_half_s);
    end else begin
      div_clk_q <= 1'b0;
    end
  end

  assign div_clk_o = div_clk_q;
`else
  assign div_clk_o = 1'b0;
`endif

endmodule

// File: tb/tb_mmd_div_ctrl.sv
// Self-checking bench for mmd_div_ctrl: expected periods, latencies and duty
// patterns are queued as stimulus is applied and popped as pulses arrive.
module tb_mmd_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic [7:0] n_int_i;
  logic [3:0] y_i;
  logic       y_req_o;
  logic       div_o;
  logic       div_clk_o;
  logic       sat_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  mmd_div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .n_int_i   (n_int_i),
    .y_i       (y_i),
    .y_req_o   (y_req_o),
    .div_o     (div_o),
    .div_clk_o (div_clk_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_pulse(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (div_o === 1'b1) begin
        t = cyc;
        break;
      end
    end
    total++;
    if (t < 0) begin
      bad++;
      $display("FAIL pulse_wait: got no div_o, want one within %0d cycles", budget);
    end
  endtask

  task automatic stop_run();
    en_i = 1'b0;
    repeat (262) @(negedge clk);
  endtask

  task automatic test_reset();
    int t, c0, e;
    rst_n = 1'b0; en_i = 1'b1; n_int_i = 8'd10; y_i = 4'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({div_o, y_req_o, div_clk_o, sat_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000", {div_o, y_req_o, div_clk_o, sat_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    exp_q.push_back(2);
    wait_pulse(6, t);
    e = exp_q.pop_front();
    total++;
    if (t - c0 !== e) begin
      bad++;
      $display("FAIL reset_latency: got %0d want %0d", t - c0, e);
    end
    stop_run();
  endtask

  task automatic test_constant();
    int t, tp, e;
    n_int_i = 8'd10; y_i = 4'h0; en_i = 1'b1;
    wait_pulse(6, tp);
    for (int k = 0; k < 3; k++) exp_q.push_back(10);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(20, t);
      e = exp_q.pop_front();
      total++;
      if (t - tp !== e) begin
        bad++;
        $display("FAIL const_period: got %0d want %0d", t - tp, e);
      end
      total++;
      if ({y_req_o, sat_o} !== 2'b10) begin
        bad++;
        $display("FAIL const_req_sat: got %b want 10", {y_req_o, sat_o});
      end
      tp = t;
    end
    stop_run();
  endtask

  task automatic test_dither();
    int t, tp, e;
    logic [3:0] ys [0:3];
    ys[0] = 4'h4; ys[1] = 4'hD; ys[2] = 4'h1; ys[3] = 4'h0;
    n_int_i = 8'd8; y_i = ys[0]; en_i = 1'b1;
    wait_pulse(6, tp);
    y_i = ys[1];
    exp_q.push_back(12); exp_q.push_back(5); exp_q.push_back(9);
    for (int k = 1; k < 4; k++) begin
      wait_pulse(20, t);
      e = exp_q.pop_front();
      total++;
      if (t - tp !== e) begin
        bad++;
        $display("FAIL dither_period: got %0d want %0d", t - tp, e);
      end
      tp = t;
      if (k < 3) y_i = ys[k+1];
    end
    stop_run();
  endtask

  task automatic test_clamp();
    int t, tp, e;
    n_int_i = 8'd2; y_i = 4'hD; en_i = 1'b1;
    wait_pulse(6, tp);
    total++;
    if (sat_o !== 1'b1) begin
      bad++;
      $display("FAIL clamp_low_sat: got %b want 1", sat_o);
    end
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(255);
    for (int k = 1; k < 4; k++) begin
      wait_pulse(300, t);
      e = exp_q.pop_front();
      total++;
      if (t - tp !== e) begin
        bad++;
        $display("FAIL clamp_period: got %0d want %0d", t - tp, e);
      end
      tp = t;
      if (k == 1) begin
        n_int_i = 8'd255; y_i = 4'h4;
      end
    end
    total++;
    if (sat_o !== 1'b1) begin
      bad++;
      $display("FAIL clamp_high_sat: got %b want 1", sat_o);
    end
    stop_run();
    total++;
    if ({sat_o, div_o} !== 2'b10) begin
      bad++;
      $display("FAIL clamp_idle_sticky: got %b want 10", {sat_o, div_o});
    end
    n_int_i = 8'd10; y_i = 4'h0; en_i = 1'b1;
    wait_pulse(6, t);
    total++;
    if (sat_o !== 1'b0) begin
      bad++;
      $display("FAIL clamp_restart_clear: got %b want 0", sat_o);
    end
    stop_run();
  endtask

  task automatic test_stop_duty();
    int t, e, pulses, highs;
    n_int_i = 8'd5; y_i = 4'h0; en_i = 1'b1;
    wait_pulse(6, t);
    for (int k = 0; k < 5; k++) begin
`ifdef MMD_DIV_CTRL_DUTY_EN
      exp_q.push_back((k < 3) ? 1 : 0);
`else
      exp_q.push_back(0);
`endif
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (div_clk_o !== e[0]) begin
        bad++;
        $display("FAIL duty_cycle%0d: got %b want %b", k, div_clk_o, e[0]);
      end
      if (k == 2) en_i = 1'b0;
    end
    pulses = 0; highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (div_o === 1'b1) pulses++;
      if (div_clk_o === 1'b1) highs++;
    end
    total++;
    if (pulses !== 0 || highs !== 0) begin
      bad++;
      $display("FAIL stop_no_pulse: got pulses=%0d clk_high=%0d want 0 0", pulses, highs);
    end
  endtask

  task automatic test_async_reset();
    int t, c0, pulses;
    n_int_i = 8'd2; y_i = 4'hD; en_i = 1'b1;
    wait_pulse(6, t);
    #1;
    rst_n = 1'b0; en_i = 1'b0;
    #1;
    total++;
    if ({div_o, y_req_o, div_clk_o, sat_o} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset_drop: got %b want 0000", {div_o, y_req_o, div_clk_o, sat_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (div_o === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL async_idle: got %0d pulses want 0", pulses);
    end
    n_int_i = 8'd10; y_i = 4'h0; en_i = 1'b1;
    c0 = cyc;
    exp_q.push_back(2);
    wait_pulse(6, t);
    total++;
    c0 = t - c0;
    t = exp_q.pop_front();
    if (c0 !== t) begin
      bad++;
      $display("FAIL async_restart_latency: got %0d want %0d", c0, t);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_constant();
    test_dither();
    test_clamp();
    test_stop_duty();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmd_div_ctrl.md
# mmd_div_ctrl

Fractional-N divide controller that sits directly downstream of the third-order HK-MASH modulator. Each output period it adds the modulator's signed 4-bit sample to the integer divide value, clamps the sum, and counts it down. It emits one divided-clock pulse per period and a one-cycle request that advances the modulator by exactly one sample. Averaged over time, the divide ratio equals the integer part plus the fractional word driven into the modulator.

## Interface
- `N_WIDTH`, 8, width of the integer divide value and of the internal counter.
- `MIN_DIV`, 4, smallest permitted divide ratio; must be ≥ 3.
- `clk`  in  1  single clock for the block and the modulator.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  run request (level).
- `n_int_i`  in  N_WIDTH  unsigned integer divide value; sampled only at period load.
- `y_i`  in  4  modulator output, two's complement, legal range -3..+4; sampled only at period load.
- `y_req_o`  out  1  one-cycle clock-enable to the modulator, requesting the next sample.
- `div_o`  out  1  one-cycle pulse at the start of each divided period.
- `div_clk_o`  out  1  near-50% duty divided clock (see Configuration).
- `sat_o`  out  1  sticky flag: a clamp occurred since the last start.

## Operation
- Reset value of all outputs is 0. Reset puts the block in state IDLE with `cnt`=0 and `n_cur`=0.
- States:
  - IDLE → RUN when `en_i`=1. This transition clears `sat_o` and sets `cnt`=0.
  - RUN: when `cnt`≠0, `cnt` decrements.
  - RUN, `cnt`=0 and `en_i`=1 (load): compute N = clamp(`n_int_i` + sext(`y_i`)). Then set `n_cur`=N, `cnt`=N-1, `div_o`=1 and `y_req_o`=1 for that cycle.
  - RUN, `cnt`=0 and `en_i`=0: go to IDLE. No pulse, no request.
- Arithmetic: the sum is evaluated signed at N_WIDTH+2 bits.
  - Sum < `MIN_DIV` → N=`MIN_DIV`.
  - Sum > 2^N_WIDTH-1 → N=2^N_WIDTH-1.
  - Either clamp sets `sat_o`=1, which holds until the next IDLE→RUN transition or reset.
- `y_i` and `n_int_i` are don't-care except in load cycles. Mid-period changes have no effect.
- Deasserting `en_i` mid-period: the current period completes its full N cycles, then the block returns to IDLE. The next enable restarts cleanly.
- Reset mid-operation: all outputs drop asynchronously to 0. After release the block is in IDLE.

## Timing
- All outputs are registered.
- Start latency: `en_i` sampled high at edge t0 → first `div_o`/`y_req_o` high in the cycle after edge t0+1.
- Period: consecutive `div_o` pulses are exactly N cycles apart, where N is computed at the earlier pulse.
- `y_req_o` coincides with `div_o`. The modulator's new sample must be stable by the next load, which is ≥ `MIN_DIV` cycles later.
- `div_clk_o` rises in the `div_o` cycle, is high for ceil(N/2) cycles, then low for floor(N/2) cycles.

## Configuration
- Macro `MMD_DIV_CTRL_DUTY_EN`.
  - Defined: `div_clk_o` is generated as specified, using a halving compare on `n_cur`.
  - Undefined: `div_clk_o` is tied to 0 and the `n_cur`-halving logic is omitted. `div_o` and `y_req_o` are unchanged.

## Structure
- Shared package `mmd_pkg` holds:
  - `MMD_Y_WIDTH`=4;
  - the IDLE/RUN state typedef;
  - default constants `MMD_N_WIDTH`=8 and `MMD_MIN_DIV`=4.
- One sub-module, `mmd_div_sat`: combinational add, sign-extend and clamp. Outputs are N and a saturation strobe.
- Counter, state and output registers live in the top module.

## Test plan
- Reset: hold `rst_n`=0 with `en_i`=1 → all outputs 0. Release → first `div_o` at the second edge after `en_i` is sampled.
- Constant divide: `n_int_i`=10, `y_i`=0 → `div_o` every 10 cycles, `y_req_o` coincident, `sat_o`=0.
- Dither: `n_int_i`=8, `y_i` sequence +4, -3, +1 presented per request → periods 12, 5, 9 cycles.
- Clamp: `n_int_i`=2, `y_i`=-3 → period 4 and `sat_o`=1. Then `n_int_i`=255, `y_i`=+4 → period 255, `sat_o` still 1. Toggle `en_i` through IDLE → `sat_o`=0.
- Stop/restart and duty: `n_int_i`=5, drop `en_i` 2 cycles into a period → period finishes at 5 cycles with no further pulse. With the macro defined, `div_clk_o` is high 3 cycles and low 2.
- Async reset asserted mid-period → outputs 0 immediately with no clock edge. After release → IDLE until `en_i` is seen.
